instruction_decoder_pipe: RTL

- Registered, parametrised successor to the combinational accumulator-machine decoder.
- Accepts instructions over a valid/ready handshake and decodes them into ALU-operation or register-write controls for any register count.
- Holds the decoded word in a single output pipeline stage.
- Adds HALT/resume control, illegal-opcode detection and a retired-instruction counter.
- Sits between the fetch unit and the accumulator/register file.

---
 rtl/instruction_decoder_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instruction_decoder_pipe.sv
// Registered accumulator-machine instruction decoder: valid/ready input, one output
// pipeline stage, HALT/resume control, sticky illegal-opcode flag and retired counter.
module instruction_decoder_pipe #(
  parameter int REG_COUNT = 4,
  parameter int OP_W      = 4,
  parameter int ALU_OPS   = 7,
  parameter int CNT_W     = 16,
  localparam int RA_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
  localparam int IW       = OP_W + RA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IW-1:0]        in_instr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 resume,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      operation_code,
  output logic                 aku_enable,
  output logic [RA_W-1:0]      register_addr,
  output logic [REG_COUNT-1:0] reg_write_en,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [OP_W-1:0] OPC_STORE = OP_W'(ALU_OPS);
  localparam logic [OP_W-1:0] OPC_NOP   = OP_W'(ALU_OPS + 1);
  localparam logic [OP_W-1:0] OPC_HALT  = {OP_W{1'b1}};

  function automatic logic [REG_COUNT-1:0] onehot(input logic [RA_W-1:0] addr);
    onehot = REG_COUNT'(1'b1) << addr;
  endfunction

  logic [0:0]           state_r;
  logic [0:0]           state_next_s;
  logic                 out_valid_r;
  logic [OP_W-1:0]      operation_code_r;
  logic                 aku_enable_r;
  logic [RA_W-1:0]      register_addr_r;
  logic [REG_COUNT-1:0] reg_write_en_r;
  logic                 illegal_r;
  logic [CNT_W-1:0]     retired_r;

  logic [OP_W-1:0] opcode_s;
  logic [RA_W-1:0] addr_s;
  logic            addr_ok_s;
  logic            is_alu_s;
  logic            is_store_s;
  logic            is_nop_s;
  logic            is_halt_s;
  logic            is_illegal_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            load_s;
  logic            drain_s;

  assign opcode_s = in_instr[IW-1:RA_W];
  assign addr_s   = in_instr[RA_W-1:0];

  // Only a non-power-of-two register file can be addressed out of range.
  if (REG_COUNT == (1 << RA_W)) begin : g_addr_full
    assign addr_ok_s = 1'b1;
  end else begin : g_addr_partial
    assign addr_ok_s = ({1'b0, addr_s} < (RA_W + 1)'(REG_COUNT));
  end

  // Classify the incoming opcode; a STORE to a missing register counts as illegal.
  always_comb begin
    is_alu_s     = 1'b0;
    is_store_s   = 1'b0;
    is_nop_s     = 1'b0;
    is_halt_s    = 1'b0;
    is_illegal_s = 1'b0;
    if (opcode_s < OPC_STORE) begin
      is_alu_s = 1'b1;
    end else if (opcode_s == OPC_STORE) begin
      if (addr_ok_s) begin
        is_store_s = 1'b1;
      end else begin
        is_illegal_s = 1'b1;
      end
    end else if (opcode_s == OPC_NOP) begin
      is_nop_s = 1'b1;
    end else if (opcode_s == OPC_HALT) begin
      is_halt_s = 1'b1;
    end else begin
      is_illegal_s = 1'b1;
    end
  end

  assign in_ready_s = (state_r == ST_RUN) && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign load_s     = accept_s && (is_alu_s || is_store_s || is_nop_s);
  assign drain_s    = out_valid_r && out_ready;

  // Run/halt sequencing; resume is only meaningful while halted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && is_halt_s) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Control state: FSM, sticky illegal flag and retired-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      illegal_r <= 1'b0;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (accept_s && is_illegal_s) begin
        illegal_r <= 1'b1;
      end
      if (drain_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  // Output stage: a new word replaces the old one, otherwise it clears once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r      <= 1'b0;
      operation_code_r <= {OP_W{1'b0}};
      aku_enable_r     <= 1'b0;
      register_addr_r  <= {RA_W{1'b0}};
      reg_write_en_r   <= {REG_COUNT{1'b0}};
    end else if (load_s) begin
      out_valid_r      <= 1'b1;
      operation_code_r <= opcode_s;
      aku_enable_r     <= is_alu_s;
      register_addr_r  <= addr_s;
      reg_write_en_r   <= is_store_s ? onehot(addr_s) : {REG_COUNT{1'b0}};
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_r;
  assign operation_code = operation_code_r;
  assign aku_enable     = aku_enable_r;
  assign register_addr  = register_addr_r;
  assign reg_write_en   = reg_write_en_r;
  assign halted         = (state_r == ST_HALT);
  assign illegal        = illegal_r;
  assign retired        = retired_r;

endmodule
